// File: rtl/bmq_rate_ctrl.sv
// BMQ clock generator: divides the board clock by a run-time even divisor.
// Divisor changes, starts and stops only take effect on a period boundary.
module bmq_rate_ctrl #(
    parameter int BOARD_CLOCK = 16000000,
    parameter int BMQ_CLOCK   = 4000000,
    parameter int DIV_W       = 16
) (
    input  logic             Clock_Board_BMQ,
    input  logic             Reset_N,
    input  logic             Enable,
    input  logic             Rate_Req,
    input  logic [DIV_W-1:0] Rate_Div,
    output logic             Rate_Ack,
    output logic             Rate_Err,
    output logic             Busy,
    output logic             Clock_BMQ,
    output logic             BMQ_Rise,
    output logic             BMQ_Fall,
    output logic [DIV_W-1:0] Div_Active
);

    localparam int               DEFAULT_DIV_INT = BOARD_CLOCK / BMQ_CLOCK;
    localparam logic [DIV_W-1:0] DEFAULT_DIV     = DIV_W'(DEFAULT_DIV_INT);
    localparam logic [DIV_W-1:0] MAX_DIV         = {{(DIV_W-1){1'b1}}, 1'b0};

    localparam logic [1:0] ST_STOPPED = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PEND    = 2'd2;

    if ((DEFAULT_DIV_INT < 2) || ((DEFAULT_DIV_INT % 2) != 0)) begin : g_bad_default_div
        $error("bmq_rate_ctrl: BOARD_CLOCK/BMQ_CLOCK must be even and >= 2");
    end

    logic [1:0]       state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_pend;
    logic [DIV_W-1:0] half_m1;
    logic [DIV_W-1:0] last;
    logic             at_rise;
    logic             at_bound;
    logic             req_ok;

    function automatic logic div_valid(input logic [DIV_W-1:0] d);
        return (d[0] == 1'b0) && (d >= DIV_W'(2)) && (d <= MAX_DIV);
    endfunction

    always_comb begin
        half_m1  = (Div_Active >> 1) - DIV_W'(1);
        last     = Div_Active - DIV_W'(1);
        at_rise  = (cnt == half_m1);
        at_bound = (cnt == last);
        req_ok   = div_valid(Rate_Div);
    end

    always_ff @(posedge Clock_Board_BMQ or negedge Reset_N) begin
        if (!Reset_N) begin
            state      <= ST_STOPPED;
            cnt        <= '0;
            div_pend   <= '0;
            Div_Active <= DEFAULT_DIV;
            Clock_BMQ  <= 1'b0;
            BMQ_Rise   <= 1'b0;
            BMQ_Fall   <= 1'b0;
            Rate_Ack   <= 1'b0;
            Rate_Err   <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            Rate_Ack <= 1'b0;
            Rate_Err <= 1'b0;
            BMQ_Rise <= 1'b0;
            BMQ_Fall <= 1'b0;
            case (state)
                ST_STOPPED: begin
                    Clock_BMQ <= 1'b0;
                    cnt       <= '0;
                    if (Enable) state <= ST_RUN;
                    if (Rate_Req) begin
                        if (req_ok) begin
                            Div_Active <= Rate_Div;
                            Rate_Ack   <= 1'b1;
                        end else begin
                            Rate_Err <= 1'b1;
                        end
                    end
                end
                ST_RUN, ST_PEND: begin
                    if (at_rise) begin
                        Clock_BMQ <= 1'b1;
                        BMQ_Rise  <= 1'b1;
                        cnt       <= cnt + DIV_W'(1);
                    end else if (at_bound) begin
                        Clock_BMQ <= 1'b0;
                        BMQ_Fall  <= 1'b1;
                        cnt       <= '0;
                        if (state == ST_PEND) begin
                            Div_Active <= div_pend;
                            Rate_Ack   <= 1'b1;
                            Busy       <= 1'b0;
                        end
                        state <= Enable ? ST_RUN : ST_STOPPED;
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                    // A request arriving on a stopping boundary is applied at once
                    if (Rate_Req) begin
                        if (!req_ok || Busy) begin
                            Rate_Err <= 1'b1;
                        end else if (at_bound && !at_rise && !Enable) begin
                            Div_Active <= Rate_Div;
                            Rate_Ack   <= 1'b1;
                        end else begin
                            div_pend <= Rate_Div;
                            Busy     <= 1'b1;
                            state    <= ST_PEND;
                        end
                    end
                end
                default: begin
                    state     <= ST_STOPPED;
                    cnt       <= '0;
                    Clock_BMQ <= 1'b0;
                    Busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bmq_rate_ctrl.sv
// Directed bench for bmq_rate_ctrl: start/stop, rate changes, errors, Div=2, reset.
module tb_bmq_rate_ctrl;

    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             Reset_N;
    logic             Enable;
    logic             Rate_Req;
    logic [DIV_W-1:0] Rate_Div;
    logic             Rate_Ack;
    logic             Rate_Err;
    logic             Busy;
    logic             Clock_BMQ;
    logic             BMQ_Rise;
    logic             BMQ_Fall;
    logic [DIV_W-1:0] Div_Active;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bmq_rate_ctrl #(
        .BOARD_CLOCK(16000000),
        .BMQ_CLOCK  (4000000),
        .DIV_W      (DIV_W)
    ) dut (
        .Clock_Board_BMQ(clk),
        .Reset_N        (Reset_N),
        .Enable         (Enable),
        .Rate_Req       (Rate_Req),
        .Rate_Div       (Rate_Div),
        .Rate_Ack       (Rate_Ack),
        .Rate_Err       (Rate_Err),
        .Busy           (Busy),
        .Clock_BMQ      (Clock_BMQ),
        .BMQ_Rise       (BMQ_Rise),
        .BMQ_Fall       (BMQ_Fall),
        .Div_Active     (Div_Active)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        Enable   = 1'b0;
        Rate_Req = 1'b0;
        Rate_Div = '0;
        Reset_N  = 1'b0;
        step();
        step();
        Reset_N = 1'b1;
        step();
    endtask

    // Enable sampled at the next edge (k=0 of the running phase)
    task automatic start_run();
        Enable = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (Div_Active !== 16'd4) begin n_fail++; $display("FAIL reset_div got %0d want 4", Div_Active); end
        n_checks++;
        if ({Clock_BMQ, BMQ_Rise, BMQ_Fall, Rate_Ack, Rate_Err, Busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outs got %b want 000000", {Clock_BMQ, BMQ_Rise, BMQ_Fall, Rate_Ack, Rate_Err, Busy});
        end
        step();
        n_checks++;
        if (Clock_BMQ !== 1'b0) begin n_fail++; $display("FAIL stopped_clk got %b want 0", Clock_BMQ); end
    endtask

    task automatic test_start();
        logic ec, er, ef;
        do_reset();
        start_run();
        for (int k = 0; k < 12; k++) begin
            if (k > 0) step();
            ec = ((k % 4) == 2) || ((k % 4) == 3);
            er = ((k % 4) == 2);
            ef = ((k % 4) == 0) && (k > 0);
            n_checks++;
            if ({Clock_BMQ, BMQ_Rise, BMQ_Fall} !== {ec, er, ef}) begin
                n_fail++;
                $display("FAIL start_wave k=%0d got clk/rise/fall=%b want %b", k, {Clock_BMQ, BMQ_Rise, BMQ_Fall}, {ec, er, ef});
            end
        end
    endtask

    task automatic test_rate_change();
        logic ec;
        do_reset();
        start_run();
        step();
        step();
        Rate_Req = 1'b1;
        Rate_Div = 16'd8;
        step();
        Rate_Req = 1'b0;
        n_checks++;
        if ({Busy, Clock_BMQ, Rate_Ack} !== 3'b110 || Div_Active !== 16'd4) begin
            n_fail++;
            $display("FAIL rc_pending got busy/clk/ack=%b div=%0d want 110 div=4", {Busy, Clock_BMQ, Rate_Ack}, Div_Active);
        end
        step();
        n_checks++;
        if ({Rate_Ack, Busy, Clock_BMQ, BMQ_Fall} !== 4'b1001 || Div_Active !== 16'd8) begin
            n_fail++;
            $display("FAIL rc_ack got ack/busy/clk/fall=%b div=%0d want 1001 div=8", {Rate_Ack, Busy, Clock_BMQ, BMQ_Fall}, Div_Active);
        end
        for (int k = 5; k <= 12; k++) begin
            step();
            ec = (k >= 8) && (k <= 11);
            n_checks++;
            if (Clock_BMQ !== ec || Rate_Ack !== 1'b0) begin
                n_fail++;
                $display("FAIL rc_wave k=%0d got clk=%b ack=%b want clk=%b ack=0", k, Clock_BMQ, Rate_Ack, ec);
            end
        end
    endtask

    task automatic test_invalid();
        logic [DIV_W-1:0] bad [3];
        bit               seen;
        bad[0] = 16'd3;
        bad[1] = 16'd0;
        bad[2] = 16'd1;
        do_reset();
        start_run();
        step();
        for (int i = 0; i < 3; i++) begin
            Rate_Req = 1'b1;
            Rate_Div = bad[i];
            step();
            n_checks++;
            if ({Rate_Err, Rate_Ack, Busy} !== 3'b100 || Div_Active !== 16'd4) begin
                n_fail++;
                $display("FAIL inv_err div=%0d got err/ack/busy=%b active=%0d want 100 active=4", bad[i], {Rate_Err, Rate_Ack, Busy}, Div_Active);
            end
        end
        Rate_Req = 1'b0;
        step();
        n_checks++;
        if (Rate_Err !== 1'b0) begin n_fail++; $display("FAIL inv_err_clear got %b want 0", Rate_Err); end
        Rate_Req = 1'b1;
        Rate_Div = 16'd8;
        step();
        n_checks++;
        if ({Busy, Rate_Err} !== 2'b10) begin n_fail++; $display("FAIL inv_first got busy/err=%b want 10", {Busy, Rate_Err}); end
        Rate_Div = 16'd6;
        step();
        Rate_Req = 1'b0;
        n_checks++;
        if ({Busy, Rate_Err} !== 2'b11) begin n_fail++; $display("FAIL inv_busy_err got busy/err=%b want 11", {Busy, Rate_Err}); end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = Rate_Ack;
        end
        n_checks++;
        if (!seen || Div_Active !== 16'd8) begin
            n_fail++;
            $display("FAIL inv_pending_kept got ack_seen=%0d div=%0d want 1 div=8", seen, Div_Active);
        end
    endtask

    task automatic test_stop();
        do_reset();
        start_run();
        step();
        step();
        Enable = 1'b0;
        step();
        n_checks++;
        if (Clock_BMQ !== 1'b1) begin n_fail++; $display("FAIL stop_hold_high got %b want 1", Clock_BMQ); end
        step();
        n_checks++;
        if ({Clock_BMQ, BMQ_Fall} !== 2'b01) begin n_fail++; $display("FAIL stop_fall got clk/fall=%b want 01", {Clock_BMQ, BMQ_Fall}); end
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++;
            if ({Clock_BMQ, BMQ_Rise} !== 2'b00) begin
                n_fail++;
                $display("FAIL stop_idle i=%0d got clk/rise=%b want 00", i, {Clock_BMQ, BMQ_Rise});
            end
        end
        start_run();
        step();
        Rate_Req = 1'b1;
        Rate_Div = 16'd8;
        Enable   = 1'b0;
        step();
        Rate_Req = 1'b0;
        n_checks++;
        if ({Busy, Clock_BMQ} !== 2'b11) begin n_fail++; $display("FAIL stop_pend got busy/clk=%b want 11", {Busy, Clock_BMQ}); end
        step();
        step();
        n_checks++;
        if ({Rate_Ack, Busy, Clock_BMQ} !== 3'b100 || Div_Active !== 16'd8) begin
            n_fail++;
            $display("FAIL stop_pend_ack got ack/busy/clk=%b div=%0d want 100 div=8", {Rate_Ack, Busy, Clock_BMQ}, Div_Active);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if (Clock_BMQ !== 1'b0) begin n_fail++; $display("FAIL stop_pend_idle i=%0d got %b want 0", i, Clock_BMQ); end
        end
    endtask

    task automatic test_div2();
        logic odd;
        do_reset();
        Rate_Req = 1'b1;
        Rate_Div = 16'd2;
        step();
        Rate_Req = 1'b0;
        n_checks++;
        if ({Rate_Ack, Busy} !== 2'b10 || Div_Active !== 16'd2) begin
            n_fail++;
            $display("FAIL div2_stopped_ack got ack/busy=%b div=%0d want 10 div=2", {Rate_Ack, Busy}, Div_Active);
        end
        step();
        n_checks++;
        if ({Rate_Ack, Busy} !== 2'b00) begin n_fail++; $display("FAIL div2_ack_once got ack/busy=%b want 00", {Rate_Ack, Busy}); end
        start_run();
        for (int k = 1; k <= 8; k++) begin
            step();
            odd = (k % 2) == 1;
            n_checks++;
            if ({Clock_BMQ, BMQ_Rise, BMQ_Fall} !== {odd, odd, !odd}) begin
                n_fail++;
                $display("FAIL div2_wave k=%0d got clk/rise/fall=%b want %b", k, {Clock_BMQ, BMQ_Rise, BMQ_Fall}, {odd, odd, !odd});
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        start_run();
        step();
        Rate_Req = 1'b1;
        Rate_Div = 16'd8;
        step();
        Rate_Req = 1'b0;
        n_checks++;
        if ({Busy, Clock_BMQ} !== 2'b11) begin n_fail++; $display("FAIL rst_mid_pre got busy/clk=%b want 11", {Busy, Clock_BMQ}); end
        Reset_N = 1'b0;
        #1;
        n_checks++;
        if ({Busy, Clock_BMQ} !== 2'b00 || Div_Active !== 16'd4) begin
            n_fail++;
            $display("FAIL rst_mid_async got busy/clk=%b div=%0d want 00 div=4", {Busy, Clock_BMQ}, Div_Active);
        end
        step();
        Reset_N = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (Rate_Ack !== 1'b0 || Div_Active !== 16'd4) begin
                n_fail++;
                $display("FAIL rst_mid_no_ack i=%0d got ack=%b div=%0d want ack=0 div=4", i, Rate_Ack, Div_Active);
            end
        end
    endtask

    initial begin
        Reset_N  = 1'b0;
        Enable   = 1'b0;
        Rate_Req = 1'b0;
        Rate_Div = '0;
        test_reset();
        test_start();
        test_rate_change();
        test_invalid();
        test_stop();
        test_div2();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout reached at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bmq_rate_ctrl.md
# bmq_rate_ctrl

Run-time controller for the encoder (BMQ) clock. It divides the board BMQ clock by a programmable even divisor to produce the 2x-code-rate BMQ clock and one-cycle edge strobes. It accepts rate-change requests through a request/ack handshake and applies them only at a period boundary, so the output never glitches. It starts and stops the BMQ clock on period boundaries under an enable. It sits between the board clock input and the encoder datapath, and is configured by the control logic.

## Interface
- BOARD_CLOCK, 16000000, board BMQ input clock frequency in Hz.
- BMQ_CLOCK, 4000000, reset-time BMQ clock frequency (2x code rate) in Hz.
- DIV_W, 16, width of divisor and counter.
- DEFAULT_DIV = BOARD_CLOCK/BMQ_CLOCK (derived). Elaboration fails unless the value is even and ≥2.

Ports:
- Clock_Board_BMQ  in  1  sole clock, rising edge.
- Reset_N  in  1  asynchronous, active-low reset.
- Enable  in  1  level; 1 = run the BMQ clock.
- Rate_Req  in  1  one-cycle request to change the divisor.
- Rate_Div  in  DIV_W  requested divisor (board clocks per BMQ period); sampled with Rate_Req.
- Rate_Ack  out  1  one-cycle pulse: new divisor now active.
- Rate_Err  out  1  one-cycle pulse: request rejected.
- Busy  out  1  a change is pending.
- Clock_BMQ  out  1  registered BMQ clock.
- BMQ_Rise  out  1  high in the first cycle Clock_BMQ is 1.
- BMQ_Fall  out  1  high in the first cycle Clock_BMQ is 0 after a high phase.
- Div_Active  out  DIV_W  divisor currently in use.

## Operation
- Reset values:
  - State STOPPED.
  - Cnt = 0.
  - Div_Active = DEFAULT_DIV.
  - Clock_BMQ, BMQ_Rise, BMQ_Fall, Rate_Ack, Rate_Err, Busy all 0.
  - The pending divisor register is cleared.
- States are STOPPED, RUN and PEND (running with a change pending).
- Counter in RUN/PEND: Cnt steps 0..Div_Active-1.
  - At the edge with Cnt == Div_Active/2-1: Clock_BMQ←1, BMQ_Rise←1, Cnt++.
  - At the edge with Cnt == Div_Active-1 (the boundary): Clock_BMQ←0, BMQ_Fall←1, Cnt←0.
  - For Div_Active = 2, both conditions fire on alternate edges.
  - Result: the low phase is Div/2 cycles and the high phase is Div/2 cycles (50% duty).
- STOPPED:
  - Clock_BMQ held 0 and Cnt held 0.
  - Enable=1 at an edge → RUN, with Cnt counting from 0 on the next edge.
- Validity of Rate_Div: even, ≥2, and ≤2^DIV_W−2.
  - Invalid → Rate_Err pulse on the next cycle; nothing else changes.
- Rate_Req with Busy=1 → dropped and Rate_Err pulse; the pending value is kept.
- Valid Rate_Req in STOPPED → Div_Active←Rate_Div at that edge, with Rate_Ack pulse in the following cycle. Busy is never raised.
- Valid Rate_Req in RUN → value latched, Busy←1, state PEND.
- At the boundary in PEND:
  - Div_Active←pending value, Cnt←0, Clock_BMQ←0.
  - Rate_Ack pulse and Busy←0, state RUN.
  - The new period starts with its low phase.
- Enable=0 in RUN/PEND: running continues to the boundary, then state goes to STOPPED. No partial high phase occurs.
  - Boundary in PEND with Enable=0: the divisor is applied and Ack'd, then state goes to STOPPED.
  - Enable back to 1 before the boundary: the stop is cancelled.
- Reset mid-operation: all outputs return to their reset values immediately. A pending request is lost and no Ack is issued.
- Arithmetic:
  - Div/2 is a shift.
  - Compares are DIV_W-bit unsigned.
  - Cnt never exceeds Div_Active−1 and wraps only via the boundary.

## Timing
- All outputs are registered and change only on a rising edge of Clock_BMQ_Board, or asynchronously on reset.
- Start latency: Enable sampled 1 at edge E0 (STOPPED). The first Clock_BMQ rise is at edge E0+Div/2.
- Stop latency: Clock_BMQ falls on the first boundary after Enable is sampled 0. This is at most Div−1 cycles later.
- Rate change latency from Rate_Req edge R (RUN):
  - Ack and the new divisor arrive at the next boundary.
  - That is at most Div_old cycles later.
  - A request at the boundary edge itself waits a full period.
- Timing of the strobes relative to Clock_BMQ:
  - BMQ_Rise coincides with the first high cycle.
  - BMQ_Fall coincides with the first low cycle.
  - Rate_Ack coincides with the first low cycle of the new period.
- Busy is high from R+1 through the Ack cycle−1.

## Test plan
- Reset release, Enable=1, defaults → Div_Active=4; Clock_BMQ = 0,0,1,1 repeating; BMQ_Rise every 4th cycle; first rise 2 cycles after Enable.
- In RUN with Div=4, Rate_Req with Rate_Div=8 mid high phase → Busy=1; Ack at the next boundary; then 4 low / 4 high cycles; no shortened phase.
- Rate_Div = 3, 0 or 1 → Rate_Err pulse, Div_Active stays 4, no Ack; a second Rate_Req=6 while Busy → Rate_Err, and the first pending value still applies.
- Enable=0 at Cnt=2 with Div=4 → Clock_BMQ stays high until Cnt=3, falls, then stays 0; Enable=0 plus a pending change → Ack at the same boundary and STOPPED.
- Div=2 → Clock_BMQ toggles every cycle with Rise/Fall alternating; Rate_Req=2 in STOPPED → Ack next cycle, no Busy.
- Reset_N low while PEND with Clock_BMQ=1 → Clock_BMQ=0, Busy=0, Div_Active=4 immediately; no Ack after release.
